// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit ramp / DAC formatting stage.
// Also holds the raised-cosine gain table used when TXRAMP_COSINE_EN is defined.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    RAMP_UP,
    ON,
    RAMP_DOWN,
    LAG
  } tx_state_t;

  localparam logic [7:0] DAC_MIDSCALE = 8'h80;

  typedef struct packed {
    logic       valid;
    logic [7:0] i;
    logic [7:0] q;
  } iq_sample_t;

  // round(len*(1-cos(pi*k/len))/2); tabulated for the 8-sample ramp, linear otherwise.
  function automatic int unsigned cos_gain(input int unsigned k, input int unsigned ramp_len);
    int unsigned g;
    g = k;
    if (ramp_len == 8) begin
      case (k)
        0:       g = 0;
        1:       g = 0;
        2:       g = 1;
        3:       g = 2;
        4:       g = 4;
        5:       g = 6;
        6:       g = 7;
        default: g = 8;
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/tx_ramp_dac_delay.sv
// iq_delay_line: fixed-depth shift register of I/Q samples advancing on each strobe.
// The head is the oldest entry, i.e. the sample taken DEPTH strobes ago.
module iq_delay_line
  import tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       shift_en,
  input  iq_sample_t din,
  output iq_sample_t head
);

  iq_sample_t line [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < DEPTH; n++) line[n] <= '0;
    end else if (shift_en) begin
      line[0] <= din;
      for (int n = 1; n < DEPTH; n++) line[n] <= line[n-1];
    end
  end

  assign head = line[DEPTH-1];

endmodule

// File: rtl/tx_ramp_dac.sv
// Burst delay, power ramp envelope, offset-binary conversion and PA enable sequencing.
// Optional macro TXRAMP_COSINE_EN selects a raised-cosine ramp instead of a linear one.
module tx_ramp_dac
  import tx_pkg::*;
#(
  parameter int RAMP_LOG2 = 3,
  parameter int PA_LEAD   = 4,
  parameter int PA_LAG    = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample_strobe,
  input  logic       iq_valid,
  input  logic [7:0] in_i,
  input  logic [7:0] in_q,
  output logic [7:0] dac_i,
  output logic [7:0] dac_q,
  output logic       dac_strobe,
  output logic       pa_enable,
  output logic       busy,
  output logic       burst_overrun,
  output tx_state_t  state_dbg
);

  // Interface timing: sample_strobe is a one-cycle qualifier with no back-pressure;
  // iq_valid/in_i/in_q are sampled only when it is high, and every output changes
  // only in the cycle after a strobe, which dac_strobe marks.

  localparam int RAMP_LEN = 1 << RAMP_LOG2;
  localparam int KW       = RAMP_LOG2 + 1;
  localparam int CW       = 8;

  tx_state_t        state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    gain;
  logic [CW-1:0]    lead_cnt;
  logic [CW-1:0]    lag_cnt;
  logic [7:0]       held_i;
  logic [7:0]       held_q;
  logic             accept;
  iq_sample_t       line_in;
  iq_sample_t       head;
  logic [7:0]       head_i_s;
  logic [7:0]       head_q_s;
  logic [7:0]       held_i_s;
  logic [7:0]       held_q_s;

  function automatic logic [7:0] scale(input logic [7:0] s, input logic [KW-1:0] g);
    logic signed [KW+8:0] p;
    p = $signed(s) * $signed({1'b0, g});
    return p[RAMP_LOG2 +: 8];
  endfunction

  function automatic logic [7:0] to_offset(input logic [7:0] x);
    return {~x[7], x[6:0]};
  endfunction

`ifdef TXRAMP_COSINE_EN
  assign gain = KW'(cos_gain(32'(k), RAMP_LEN));
`else
  assign gain = k;
`endif

  // Once the ramp-down starts the burst is over; late samples are refused.
  assign accept = !(state == RAMP_DOWN || state == LAG);

  always_comb begin
    line_in       = '0;
    line_in.valid = iq_valid && accept;
    line_in.i     = in_i;
    line_in.q     = in_q;
  end

  iq_delay_line #(.DEPTH(PA_LEAD)) u_delay (
    .clock    (clock),
    .reset_n  (reset_n),
    .shift_en (sample_strobe),
    .din      (line_in),
    .head     (head)
  );

  assign head_i_s  = scale(head.i, gain);
  assign head_q_s  = scale(head.q, gain);
  assign held_i_s  = scale(held_i, gain);
  assign held_q_s  = scale(held_q, gain);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      k             <= '0;
      lead_cnt      <= '0;
      lag_cnt       <= '0;
      held_i        <= '0;
      held_q        <= '0;
      dac_i         <= DAC_MIDSCALE;
      dac_q         <= DAC_MIDSCALE;
      dac_strobe    <= 1'b0;
      pa_enable     <= 1'b0;
      burst_overrun <= 1'b0;
    end else begin
      dac_strobe    <= sample_strobe;
      burst_overrun <= sample_strobe && iq_valid && !accept;
      if (sample_strobe) begin
        case (state)
          IDLE: begin
            dac_i <= DAC_MIDSCALE;
            dac_q <= DAC_MIDSCALE;
            if (iq_valid) begin
              pa_enable <= 1'b1;
              lead_cnt  <= '0;
              if (PA_LEAD == 1) begin
                state <= RAMP_UP;
                k     <= KW'(1);
              end else begin
                state <= LEAD;
              end
            end
          end
          LEAD: begin
            dac_i <= DAC_MIDSCALE;
            dac_q <= DAC_MIDSCALE;
            if (lead_cnt == CW'(PA_LEAD - 2)) begin
              state <= RAMP_UP;
              k     <= KW'(1);
            end else begin
              lead_cnt <= lead_cnt + CW'(1);
            end
          end
          RAMP_UP: begin
            if (head.valid) begin
              dac_i  <= to_offset(head_i_s);
              dac_q  <= to_offset(head_q_s);
              held_i <= head.i;
              held_q <= head.q;
              if (k == KW'(RAMP_LEN)) state <= ON;
              else                    k     <= k + KW'(1);
            end else begin
              // k already points one past the gain last applied; restart one below it.
              state <= RAMP_DOWN;
              k     <= (k >= KW'(2)) ? k - KW'(2) : '0;
            end
          end
          ON: begin
            if (head.valid) begin
              dac_i  <= to_offset(head.i);
              dac_q  <= to_offset(head.q);
              held_i <= head.i;
              held_q <= head.q;
            end else begin
              state <= RAMP_DOWN;
              k     <= KW'(RAMP_LEN - 1);
            end
          end
          RAMP_DOWN: begin
            dac_i <= to_offset(held_i_s);
            dac_q <= to_offset(held_q_s);
            if (k == '0) begin
              state   <= LAG;
              lag_cnt <= '0;
            end else begin
              k <= k - KW'(1);
            end
          end
          LAG: begin
            dac_i <= DAC_MIDSCALE;
            dac_q <= DAC_MIDSCALE;
            if (lag_cnt == CW'(PA_LAG - 1)) begin
              state     <= IDLE;
              pa_enable <= 1'b0;
            end else begin
              lag_cnt <= lag_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_ramp_dac.sv
// Randomised scoreboard bench for tx_ramp_dac against a burst-level reference model.
module tb_tx_ramp_dac;
  import tx_pkg::*;

  localparam int RL     = 8;
  localparam int LEAD_N = 4;
  localparam int LAG_N  = 4;
  localparam int MAXN   = 1024;
  localparam int EW     = 19;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_strobe = 1'b0;
  logic       iq_valid = 1'b0;
  logic [7:0] in_i = 8'h00;
  logic [7:0] in_q = 8'h00;
  logic [7:0] dac_i, dac_q;
  logic       dac_strobe, pa_enable, busy, burst_overrun;
  tx_state_t  state_dbg;

  logic          sv [MAXN];
  logic [7:0]    si [MAXN];
  logic [7:0]    sq [MAXN];
  int            sgap [MAXN];
  logic [EW-1:0] ev [MAXN];
  int            n_stim = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  logic [EW-1:0] mon_e;
  logic          mon_en = 1'b0;
  int            total = 0;
  int            bad = 0;
  int            n_ss = 0;
  int            n_ds = 0;

  always #5 clock = ~clock;

  tx_ramp_dac dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sample_strobe (sample_strobe),
    .iq_valid      (iq_valid),
    .in_i          (in_i),
    .in_q          (in_q),
    .dac_i         (dac_i),
    .dac_q         (dac_q),
    .dac_strobe    (dac_strobe),
    .pa_enable     (pa_enable),
    .busy          (busy),
    .burst_overrun (burst_overrun),
    .state_dbg     (state_dbg)
  );

  function automatic logic [EW-1:0] pack(input logic [7:0] di, input logic [7:0] dq,
                                         input logic pa, input logic bz, input logic ov);
    return {di, dq, pa, bz, ov};
  endfunction

  function automatic int gain_f(input int k);
`ifdef TXRAMP_COSINE_EN
    real x;
    x = RL * (1.0 - $cos(3.141592653589793 * k / RL)) / 2.0;
    return int'($floor(x + 0.5));
`else
    return k;
`endif
  endfunction

  // Signed sample times gain, floor-divided by the ramp length, then offset by midscale.
  function automatic logic [7:0] sc(input logic [7:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    p = p >>> $clog2(RL);
    return 8'(p + 128);
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got i=%h q=%h pa=%b busy=%b bit0=%b, want i=%h q=%h pa=%b busy=%b bit0=%b",
               name, $time, act[18:11], act[10:3], act[2], act[1], act[0],
               expv[18:11], expv[10:3], expv[2], expv[1], expv[0]);
    end
  endtask

  // Reference: locate each burst in the stimulus and lay out its lead, ramp, hold, ramp-down and lag.
  task automatic build_expected(input int n);
    int t, t0, len, lg, h, fin, s, g;
    logic [7:0] hi, hq;
    for (int x = 0; x < n; x++) ev[x] = pack(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (t < n) begin
      if (!sv[t]) begin
        t++;
        continue;
      end
      t0 = t;
      len = 0;
      while (t0 + len < n && sv[t0 + len]) len++;
      lg  = (len < RL) ? len : RL;
      h   = t0 + LEAD_N + len;
      fin = h + lg + LAG_N;
      hi  = si[t0 + len - 1];
      hq  = sq[t0 + len - 1];
      for (int x = t0; x < fin && x < n; x++) begin
        ev[x][2] = 1'b1;
        ev[x][1] = 1'b1;
      end
      for (int j = 0; j < len; j++) begin
        s = t0 + LEAD_N + j;
        g = (j < RL) ? gain_f(j + 1) : RL;
        if (s < n) ev[s][18:3] = {sc(si[t0 + j], g), sc(sq[t0 + j], g)};
      end
      if (h < n) ev[h][18:3] = ev[h - 1][18:3];
      for (int m = 0; m < lg; m++) begin
        s = h + 1 + m;
        if (s < n) ev[s][18:3] = {sc(hi, gain_f(lg - 1 - m)), sc(hq, gain_f(lg - 1 - m))};
      end
      for (int x = h + 1; x <= fin && x < n; x++) if (sv[x]) ev[x][0] = 1'b1;
      t = fin + 1;
    end
  endtask

  task automatic add(input logic v, input logic [7:0] i, input logic [7:0] q, input int gap);
    if (n_stim < MAXN) begin
      sv[n_stim] = v;
      si[n_stim] = i;
      sq[n_stim] = q;
      sgap[n_stim] = gap;
      n_stim++;
    end
  endtask

  task automatic pad(input int cnt, input int gap);
    for (int x = 0; x < cnt; x++) add(1'b0, 8'($urandom), 8'($urandom), gap);
  endtask

  // Called at a falling edge; holds the strobe across exactly one rising edge.
  task automatic drive_sample(input logic v, input logic [7:0] i, input logic [7:0] q, input int gap);
    sample_strobe = 1'b1;
    iq_valid = v;
    in_i = i;
    in_q = q;
    @(negedge clock);
    sample_strobe = 1'b0;
    repeat (gap - 1) @(negedge clock);
  endtask

  task automatic run_scenario();
    build_expected(n_stim);
    for (int t = 0; t < n_stim; t++) begin
      exp_q.push_back(ev[t]);
      drive_sample(sv[t], si[t], sq[t], sgap[t]);
    end
    for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge clock);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d expected outputs never appeared, want 0", exp_q.size());
      exp_q.delete();
    end
    n_stim = 0;
  endtask

  always @(posedge clock) if (reset_n && sample_strobe) n_ss++;

  always @(negedge clock) begin
    if (reset_n) begin
      if (dac_strobe) n_ds++;
      if (mon_en) begin
        if (dac_strobe) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_dac_strobe at %0t: got a strobe, want none queued", $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("dac_sample", {dac_i, dac_q, pa_enable, busy, burst_overrun}, mon_e);
            last_exp = {mon_e[EW-1:1], 1'b0};
          end
        end else begin
          check("hold_between_strobes", {dac_i, dac_q, pa_enable, busy, burst_overrun}, last_exp);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_state", {dac_i, dac_q, pa_enable, busy, dac_strobe}, pack(8'h80, 8'h80, 1'b0, 1'b0, 1'b0));
    last_exp = pack(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // 20-sample constant burst, back-to-back strobes
    for (int x = 0; x < 20; x++) add(1'b1, 8'd64, 8'hC0, 1);
    pad(30, 1);
    run_scenario();

    // same burst with widely spaced strobes
    for (int x = 0; x < 20; x++) add(1'b1, 8'd64, 8'hC0, 16);
    pad(30, 16);
    run_scenario();

    // single-sample burst at negative full scale
    add(1'b1, 8'h80, 8'($urandom), 1);
    pad(30, 1);
    run_scenario();

    // burst with a two-sample gap; the tail returns while ramping down
    for (int x = 0; x < 12; x++) add(1'b1, 8'($urandom), 8'($urandom), 1);
    pad(2, 1);
    for (int x = 0; x < 10; x++) add(1'b1, 8'($urandom), 8'($urandom), 1);
    pad(40, 1);
    run_scenario();

    // random bursts, holes and strobe spacing
    for (int b = 0; b < 8; b++) begin
      pad($urandom_range(0, 8), $urandom_range(1, 3));
      for (int x = 0, len = $urandom_range(1, 24); x < len; x++)
        add($urandom_range(0, 9) != 0, 8'($urandom), 8'($urandom), $urandom_range(1, 3));
    end
    pad(40, 2);
    run_scenario();

    // reset while ON
    mon_en = 1'b0;
    for (int x = 0; x < 14; x++) drive_sample(1'b1, 8'd100, 8'h00, 1);
    @(posedge clock);
    #2;
    check("on_before_reset", {dac_i, dac_q, pa_enable, busy, burst_overrun}, pack(8'hE4, 8'h80, 1'b1, 1'b1, 1'b0));
    reset_n = 1'b0;
    iq_valid = 1'b0;
    #1;
    check("reset_async", {dac_i, dac_q, pa_enable, busy, dac_strobe}, pack(8'h80, 8'h80, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int x = 0; x < 3; x++) begin
      @(negedge clock);
      check("post_reset_quiet", {dac_i, dac_q, pa_enable, busy, dac_strobe}, pack(8'h80, 8'h80, 1'b0, 1'b0, 1'b0));
    end
    exp_q.delete();
    last_exp = pack(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // recovery burst after reset
    for (int x = 0; x < 9; x++) add(1'b1, 8'($urandom), 8'($urandom), $urandom_range(1, 2));
    pad(30, 1);
    run_scenario();

    repeat (4) @(negedge clock);
    total++;
    if (n_ds != n_ss) begin
      bad++;
      $display("FAIL strobe_count: got %0d dac strobes, want %0d", n_ds, n_ss);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
